// File: rtl/cache_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_ctrl
// Purpose  : Bridges a single-word cache request port to a RAM with a
//            FREE/BUSY/ACCESS/ERROR handshake. Latches the request, strobes
//            the RAM until ACCESS, an ERROR or a wait timeout, then reports
//            completion with a one-cycle low pulse on dwait.
// Ports    : CLK, RST            - clock, asynchronous active-high reset
//            dREN/dWEN/daddr/dstore -> cache request (held until dwait low)
//            dwait/dload         <- completion pulse (active low), read data
//            ramREN/ramWEN/ramaddr/ramstore -> RAM strobes, latched request
//            ramload/ramstate    <- RAM read data and status
//            err_clr/mem_err     - sticky error flag and its clear
//            xfer_cnt            - saturating count of successful transfers
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    input  logic              err_clr,
    output logic              mem_err,
    output logic [15:0]       xfer_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    // The wait counter is 8 bits wide; the limit is taken modulo 256.
    localparam logic [7:0] C_TIMEOUT_LIM = 8'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [7:0]        wcnt_q,  wcnt_d;
    logic [DATA_W-1:0] dload_q, dload_d;
    logic              err_q,   err_d;
    logic [15:0]       cnt_q,   cnt_d;
    logic              err_set;
    logic              req_held;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wcnt_d   = wcnt_q;
        dload_d  = dload_q;
        cnt_d    = cnt_q;
        err_set  = 1'b0;
        // The request that started the transfer is the one that must stay up.
        req_held = (state_q == S_WR) ? dWEN : dREN;

        case (state_q)
            S_IDLE: begin
                if (dWEN) begin
                    state_d = S_WR;
                    addr_d  = daddr;
                    store_d = dstore;
                    wcnt_d  = 8'd0;
                end else if (dREN) begin
                    state_d = S_RD;
                    addr_d  = daddr;
                    wcnt_d  = 8'd0;
                end
            end
            S_RD, S_WR: begin
                // ACCESS outranks everything, including a dropped request.
                if (ramstate == RS_ACCESS) begin
                    if (state_q == S_RD) begin
                        dload_d = ramload;
                    end
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    state_d = S_RESP;
                end else if ((ramstate == RS_ERROR) || (wcnt_q == C_TIMEOUT_LIM)) begin
                    err_set = 1'b1;
                    dload_d = '0;
                    state_d = S_RESP;
                end else if (!req_held) begin
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A new error in the same cycle as a clear leaves the flag set.
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            store_q <= '0;
            wcnt_q  <= 8'd0;
            dload_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wcnt_q  <= wcnt_d;
            dload_q <= dload_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes and dwait decode straight from the state register so that an
    // asynchronous reset takes them to their idle values immediately.
    assign dwait    = (state_q != S_RESP);
    assign ramREN   = (state_q == S_RD);
    assign ramWEN   = (state_q == S_WR);
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign dload    = dload_q;
    assign mem_err  = err_q;
    assign xfer_cnt = cnt_q;

endmodule
`default_nettype wire
